// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared pipeline-control types and defaults
package pipeline_ctrl_pkg;

  // Hazard unit controller states
  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } hdu_state_t;

  // Default multiply/divide occupancy of EX, in cycles (legal 2..15)
  localparam int MDU_LATENCY_DEF = 4;

  // Default width of the performance counters
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Clear wins over increment; the count sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - load-use, branch-flush and MDU stall control
module hazard_detection_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RT,
  input  logic [4:0]       IF_ID_RS,
  input  logic [4:0]       IF_ID_RT,
  input  logic             EX_BranchTaken,
  input  logic             EX_MduStart,
  input  logic             CntClear,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_Hold,
  output logic             EX_MEM_Bubble,
  output logic             MduBusy,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  // Remaining stall cycles after the first one, loaded on MDU start
  localparam logic [3:0] MDU_RELOAD = 4'(MDU_LATENCY - 2);

  hdu_state_t state, state_next;
  logic [3:0] mdu_cnt, mdu_cnt_next;
  logic       load_use;

  // A load feeding either ID source is a hazard; R0 never carries a dependency
  assign load_use = ID_EX_MemRead && (ID_EX_RT != 5'd0) &&
                    ((ID_EX_RT == IF_ID_RS) || (ID_EX_RT == IF_ID_RT));

  assign MduBusy = (state == MDU_BUSY);

  // State and MDU countdown registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      mdu_cnt <= 4'd0;
    end else begin
      state   <= state_next;
      mdu_cnt <= mdu_cnt_next;
    end
  end

  // Next-state and control outputs; branch beats MDU beats load-use in RUN
  always_comb begin
    state_next    = state;
    mdu_cnt_next  = mdu_cnt;
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    EX_Hold       = 1'b0;
    EX_MEM_Bubble = 1'b0;
    case (state)
      RUN: begin
        if (EX_BranchTaken) begin
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
        end else if (EX_MduStart) begin
          PCWrite       = 1'b0;
          IF_ID_Write   = 1'b0;
          EX_Hold       = 1'b1;
          EX_MEM_Bubble = 1'b1;
          state_next    = MDU_BUSY;
          mdu_cnt_next  = MDU_RELOAD;
        end else if (load_use) begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Flush = 1'b1;
        end
      end
      MDU_BUSY: begin
        // EX is frozen here, so branch, new MDU and load-use inputs are ignored
        if (mdu_cnt != 4'd0) begin
          PCWrite       = 1'b0;
          IF_ID_Write   = 1'b0;
          EX_Hold       = 1'b1;
          EX_MEM_Bubble = 1'b1;
          mdu_cnt_next  = mdu_cnt - 4'd1;
        end else begin
          state_next = RUN;
        end
      end
      default: begin
        state_next   = RUN;
        mdu_cnt_next = 4'd0;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~PCWrite),
    .clr   (CntClear),
    .count (StallCount)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (IF_ID_Flush),
    .clr   (CntClear),
    .count (FlushCount)
  );

endmodule
